// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready handshake, stall/flush controls and payload bundles
// between two pipeline stages.
`default_nettype none

interface pipe_stage_reg_if #(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, stall, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, stall, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic 2-entry pipeline register with a registered in_ready,
// stall/flush control, NOP (zero control) on bubbles and a bubble counter.
// Revision: 1.0
`default_nettype none

module pipe_stage_reg #(
  parameter int CTRL_W     = 32,
  parameter int DATA_W     = 128,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = 16
) (
  input  wire logic       clock,
  input  wire logic       reset,
  pipe_stage_reg_if.slave bus,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_SKID  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_out_valid;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = bus.in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready & ~bus.stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != S_SKID);
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.flush) begin
      w_next_state = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_in_fire) w_next_state = S_FULL;
        S_FULL: begin
          if (w_in_fire && !w_out_fire)      w_next_state = S_SKID;
          else if (!w_in_fire && w_out_fire) w_next_state = S_EMPTY;
        end
        S_SKID:  if (w_out_fire) w_next_state = S_FULL;
        default: w_next_state = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (!bus.flush) begin
      case (r_state)
        S_EMPTY: w_load_main_in = w_in_fire;
        S_FULL: begin
          w_load_main_in = w_in_fire & w_out_fire;
          w_load_skid    = w_in_fire & ~w_out_fire;
        end
        S_SKID:  w_load_main_skid = w_out_fire;
        default: ;
      endcase
    end
  end

  // Flush clears the entries so a killed beat cannot leak through out_data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (bus.flush) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_ctrl <= bus.in_ctrl;
        r_main_data <= bus.in_data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= bus.in_ctrl;
        r_skid_data <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (!w_out_valid) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign bubble_cnt    = r_bubble_cnt;

  generate
    if (CLEAR_DATA != 0) begin : g_clear_data
      assign bus.out_data = w_out_valid ? r_main_data : '0;
    end else begin : g_hold_data
      assign bus.out_data = r_main_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scenario tasks plus a randomized run, checked against a
// queue-based model of the stage (two DUTs: CLEAR_DATA=0/CNT_W=16 and CLEAR_DATA=1/CNT_W=4).
`default_nettype none

module tb_pipe_stage_reg;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [31:0]  in_ctrl = '0;
  logic [127:0] in_data = '0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b1;
  logic [15:0]  bubble0;
  logic [3:0]   bubble1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_stage_reg_if #(.CTRL_W(32), .DATA_W(128)) bus0 ();
  pipe_stage_reg_if #(.CTRL_W(32), .DATA_W(128)) bus1 ();

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.in_ctrl  = in_ctrl;   assign bus1.in_ctrl  = in_ctrl;
  assign bus0.in_data  = in_data;   assign bus1.in_data  = in_data;
  assign bus0.stall    = stall;     assign bus1.stall    = stall;
  assign bus0.flush    = flush;     assign bus1.flush    = flush;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

  pipe_stage_reg #(.CTRL_W(32), .DATA_W(128), .CLEAR_DATA(0), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave), .bubble_cnt(bubble0));
  pipe_stage_reg #(.CTRL_W(32), .DATA_W(128), .CLEAR_DATA(1), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave), .bubble_cnt(bubble1));

  // Reference model: a FIFO of at most two beats.
  typedef struct packed { logic [31:0] c; logic [127:0] d; } beat_t;
  beat_t        mq[$];
  logic         m_ready;
  logic [127:0] m_held;
  int unsigned  m_cnt;

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b1;
    m_held  = '0;
    m_cnt   = 0;
  endtask

  // One clock edge: inputs sampled before the edge, model advanced, then 1 time unit later.
  task automatic tick();
    bit in_f, out_f;
    beat_t b;
    in_f  = in_valid && m_ready;
    out_f = (mq.size() > 0) && out_ready && !stall;
    b.c = in_ctrl;
    b.d = in_data;
    @(posedge clock);
    if (!reset) begin
      if (mq.size() == 0) m_cnt++;
      if (flush) begin
        mq.delete();
        m_held = '0;
      end else begin
        if (out_f) void'(mq.pop_front());
        if (in_f) mq.push_back(b);
      end
      if (mq.size() > 0) m_held = mq[0].d;
      m_ready = (mq.size() < 2);
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus0.out_valid); end
    checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus0.in_ready); end
    checks++; if (bus0.out_ctrl !== 32'd0) begin errors++; $display("FAIL reset_out_ctrl got %h want 0", bus0.out_ctrl); end
    checks++; if (bus0.out_data !== 128'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus0.out_data); end
    checks++; if (bubble0 !== 16'd0 || bubble1 !== 4'd0) begin errors++; $display("FAIL reset_bubble got %0d/%0d want 0/0", bubble0, bubble1); end
  endtask

  task automatic test_streaming();
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_ctrl = i;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++; if (bus0.out_valid !== 1'b1 || bus0.out_ctrl !== 32'(i)) begin errors++; $display("FAIL stream_out beat %0d got v=%b c=%0d want v=1 c=%0d", i, bus0.out_valid, bus0.out_ctrl, i); end
      checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat %0d got %b want 1", i, bus0.in_ready); end
      checks++; if (bubble0 !== 16'd1) begin errors++; $display("FAIL stream_bubble beat %0d got %0d want 1", i, bubble0); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_skid_fill();
    logic [31:0] got[$];
    bit fire, acc;
    logic [31:0] val;
    do_reset();
    in_valid = 1'b1; in_ctrl = 32'h11;
    tick();
    stall = 1'b1; in_ctrl = 32'h22;
    tick();
    checks++; if (bus0.in_ready !== 1'b0 || bus0.out_ctrl !== 32'h11) begin errors++; $display("FAIL skid_enter got rdy=%b c=%h want rdy=0 c=11", bus0.in_ready, bus0.out_ctrl); end
    in_ctrl = 32'h33;
    repeat (2) tick();
    checks++; if (bus0.in_ready !== 1'b0 || bus0.out_ctrl !== 32'h11) begin errors++; $display("FAIL skid_hold got rdy=%b c=%h want rdy=0 c=11", bus0.in_ready, bus0.out_ctrl); end
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      fire = bus0.out_valid && out_ready && !stall;
      val  = bus0.out_ctrl;
      acc  = in_valid && bus0.in_ready;
      tick();
      if (fire) got.push_back(val);
      if (acc && in_ctrl == 32'h33) in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3 || got[0] !== 32'h11 || got[1] !== 32'h22 || got[2] !== 32'h33) begin
      errors++;
      $display("FAIL skid_order got %0d beats first=%h want 3 beats 11,22,33", got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_flush();
    bit seen;
    do_reset();
    stall = 1'b1; in_valid = 1'b1; in_ctrl = 32'h44; in_data = 128'h44;
    tick();
    in_ctrl = 32'h55; in_data = 128'h55;
    tick();
    checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_skid got rdy=%b want 0", bus0.in_ready); end
    flush = 1'b1; in_ctrl = 32'h66; in_data = 128'h66;
    tick();
    checks++; if (bus0.out_valid !== 1'b0 || bus0.out_ctrl !== 32'd0 || bus0.in_ready !== 1'b1) begin errors++; $display("FAIL flush_result got v=%b c=%h rdy=%b want v=0 c=0 rdy=1", bus0.out_valid, bus0.out_ctrl, bus0.in_ready); end
    checks++; if (bus0.out_data !== 128'd0) begin errors++; $display("FAIL flush_data got %h want 0", bus0.out_data); end
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (bus0.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_discard got out_valid=1 after flush want 0"); end
  endtask

  task automatic test_bubble_zero();
    do_reset();
    in_valid = 1'b1; in_ctrl = 32'hFF; in_data = 128'hDEAD;
    tick();
    in_valid = 1'b0;
    checks++; if (bus0.out_ctrl !== 32'hFF || bus1.out_data !== 128'hDEAD) begin errors++; $display("FAIL bubble_beat got c=%h d=%h want FF DEAD", bus0.out_ctrl, bus1.out_data); end
    tick();
    checks++; if (bus0.out_ctrl !== 32'd0 || bus1.out_ctrl !== 32'd0) begin errors++; $display("FAIL bubble_ctrl got %h/%h want 0/0", bus0.out_ctrl, bus1.out_ctrl); end
    checks++; if (bus0.out_data !== 128'hDEAD) begin errors++; $display("FAIL bubble_hold_data got %h want DEAD", bus0.out_data); end
    checks++; if (bus1.out_data !== 128'd0) begin errors++; $display("FAIL bubble_clear_data got %h want 0", bus1.out_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    stall = 1'b1; in_valid = 1'b1; in_ctrl = 32'h1; tick();
    in_ctrl = 32'h2; tick();
    checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL areset_pre got rdy=%b want 0", bus0.in_ready); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1 || bubble0 !== 16'd0) begin errors++; $display("FAIL areset got v=%b rdy=%b cnt=%0d want 0 1 0", bus0.out_valid, bus0.in_ready, bubble0); end
    idle_inputs();
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    checks++; if (bus0.out_valid !== 1'b0 || bus0.out_ctrl !== 32'd0) begin errors++; $display("FAIL areset_after got v=%b c=%h want 0 0", bus0.out_valid, bus0.out_ctrl); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    repeat (17) tick();
    checks++; if (bubble1 !== 4'd1) begin errors++; $display("FAIL wrap_cnt4 got %0d want 1", bubble1); end
    checks++; if (bubble0 !== 16'd17) begin errors++; $display("FAIL wrap_cnt16 got %0d want 17", bubble0); end
  endtask

  task automatic test_random();
    logic          ev;
    logic [31:0]   ec;
    logic [127:0]  ed1;
    int            bad;
    do_reset();
    bad = 0;
    for (int n = 0; n < 500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ctrl   = $urandom;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 5) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      tick();
      ev  = (mq.size() > 0);
      ec  = ev ? mq[0].c : 32'd0;
      ed1 = ev ? mq[0].d : 128'd0;
      checks++;
      if (bus0.out_valid !== ev || bus0.out_ctrl !== ec || bus0.in_ready !== m_ready ||
          bus0.out_data !== m_held || bus1.out_data !== ed1 ||
          bubble0 !== m_cnt[15:0] || bubble1 !== m_cnt[3:0]) begin
        errors++;
        if (bad < 5) $display("FAIL random cycle %0d got v=%b c=%h rdy=%b cnt=%0d/%0d want v=%b c=%h rdy=%b cnt=%0d/%0d",
                              n, bus0.out_valid, bus0.out_ctrl, bus0.in_ready, bubble0, bubble1,
                              ev, ec, m_ready, m_cnt[15:0], m_cnt[3:0]);
        bad++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid_fill();
    test_flush();
    test_bubble_zero();
    test_async_reset();
    test_counter_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
